// File: rtl/deshif.sv
// deshif: binary-to-one-hot decoder with a registered copy and valid flag.
// Optional DESHIF_CHG_EN adds a one-cycle chg pulse whenever y_q changes value.
module deshif #(
    parameter int SEL_W = 2,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] a,
    output logic [OUT_W-1:0] y,
    output logic [OUT_W-1:0] y_q,
    output logic             vld_q
`ifdef DESHIF_CHG_EN
    ,
    output logic             chg
`endif
);
    always_comb y = en ? OUT_W'(1) << a : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            y_q   <= y;
            vld_q <= en;
        end
    end
`ifdef DESHIF_CHG_EN
    // high during the cycle following an edge that loaded a different y_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chg <= 1'b0;
        else     chg <= y != y_q;
    end
`endif
endmodule

// File: tb/tb_deshif.sv
// tb_deshif: directed and randomized checks of deshif against a behavioural model.
// Build with DESHIF_CHG_EN defined to also check the chg output.
module tb_deshif;
    logic       clk = 1'b0;
    logic       clk_on = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] a = 2'd0;
    logic [3:0] y, y_q;
    logic       vld_q;
    logic       chg;
    int         passed = 0;
    int         total = 0;
    int         exp_yq = 0;
    int         exp_vld = 0;
    int         exp_chg = 0;

    always #5 clk = clk_on ? ~clk : clk;

    deshif dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .y(y), .y_q(y_q), .vld_q(vld_q)
`ifdef DESHIF_CHG_EN
        , .chg(chg)
`endif
    );
`ifndef DESHIF_CHG_EN
    assign chg = 1'b0;
`endif

    function automatic int model_y(input logic e, input logic [1:0] s);
        return e ? 2 ** int'(s) : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".y_q"}, 32'(y_q), 32'(exp_yq));
        check({tag, ".vld_q"}, 32'(vld_q), 32'(exp_vld));
`ifdef DESHIF_CHG_EN
        check({tag, ".chg"}, 32'(chg), 32'(exp_chg));
`endif
    endtask

    task automatic step(input string tag);
        int nyq;
        @(posedge clk);
        nyq = model_y(en, a);
        exp_chg = int'(nyq != exp_yq);
        exp_yq = nyq;
        exp_vld = int'(en);
        #1 check_regs(tag);
        @(negedge clk);
    endtask

    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        exp_yq = 0;
        exp_vld = 0;
        exp_chg = 0;
        #1 check_regs(tag);
        check({tag, ".y"}, 32'(y), 32'(model_y(en, a)));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1 check("rst.y", 32'(y), 32'(0));
        check_regs("rst");
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            #100 check("sweep.y", 32'(y), 32'(1 << i));
        end
        check_regs("noclk");
        clk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a = 2'd2;
        step("a2");
        check("a2.y_q_lit", 32'(y_q), 32'h4);
        a = 2'd3;
        step("a3");
        check("a3.y_q_lit", 32'(y_q), 32'h8);
        en = 1'b0;
        a = 2'd1;
        #1 check("dis.y", 32'(y), 32'(0));
        step("dis");
        en = 1'b1;
        a = 2'd3;
        step("pre_rst");
        mid_reset("midrst");
        check("midrst.y_lit", 32'(y), 32'h8);
        step("post_rst");
        a = 2'd0;
        #1 check("wrap.y", 32'(y), 32'h1);
        check("wrap.onehot", 32'($countones(y)), 32'd1);
        step("wrap");
        a = 2'd1;
        step("chg_a1");
        a = 2'd2;
        step("chg_a2");
        step("chg_hold");
        en = 1'b0;
        step("chg_en_off");
        en = 1'b1;
        step("chg_en_on");
        for (int i = 0; i < 300; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            a = 2'($urandom);
            #1 check("rnd.y", 32'(y), 32'(model_y(en, a)));
            if (en) check("rnd.onehot", 32'($countones(y)), 32'd1);
            if ($urandom_range(0, 19) == 0) mid_reset("rnd_rst");
            else step("rnd");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end
endmodule
